// File: rtl/slave_agent_mem_bfm_if.sv
// APB bus bundle between the master side and the memory-backed slave responder.
interface slave_agent_mem_bfm_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 1
);
   logic [NUM_SLAVES-1:0]   psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/slave_agent_mem_bfm.sv
// Autonomous APB slave responder: banked word memory, programmable waits, strobes,
// error injection, saturating transfer counters and a sticky protocol-violation flag.
module slave_agent_mem_bfm #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int NUM_SLAVES = 1,
   parameter int WAIT_WIDTH = 4
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   slave_agent_mem_bfm_if.slave  apb,
   input  logic [WAIT_WIDTH-1:0] cfg_wait_states,
   input  logic                  cfg_err_inject,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count,
   output logic [15:0]           err_count,
   output logic                  proto_err
);
   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int BYTE_SH = $clog2(STRB_W);
   localparam int IDX_W   = $clog2(MEM_DEPTH);
   localparam int BANK_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e                  state_q, state_d;
   logic [BANK_W-1:0]       bank_q, bank_d;
   logic [IDX_W-1:0]        word_q, word_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [WAIT_WIDTH-1:0]   wcnt_q, wcnt_d;
   logic                    err_q, err_d;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
   logic [15:0]             rd_cnt_q, rd_cnt_d;
   logic [15:0]             wr_cnt_q, wr_cnt_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic                    proto_q, proto_d;
   logic [DATA_WIDTH-1:0]   mem_q [NUM_SLAVES][MEM_DEPTH];

   logic [BANK_W-1:0]       bank_sel;
   logic [ADDR_WIDTH-1:0]   word_full;
   logic [IDX_W-1:0]        word_sel;
   logic                    setup_err;
   logic [DATA_WIDTH-1:0]   wr_merge;
   logic                    mem_we;

   // Lowest set psel bit picks the bank; multi-hot selects are flagged as errors below.
   always_comb begin
      bank_sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (apb.psel[i]) bank_sel = BANK_W'(i);
      end
   end

   assign word_full = apb.paddr >> BYTE_SH;
   assign word_sel  = word_full[IDX_W-1:0];
   assign setup_err = cfg_err_inject | ((word_full >> IDX_W) != '0) | !$onehot(apb.psel);

   always_comb begin
      wr_merge = mem_q[bank_q][word_q];
      for (int b = 0; b < STRB_W; b++) begin
         if (apb.pstrb[b]) wr_merge[b*8 +: 8] = apb.pwdata[b*8 +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      bank_d    = bank_q;
      word_d    = word_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      pready_d  = pready_q;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;
      proto_d   = proto_q;
      mem_we    = 1'b0;
      case (state_q)
         IDLE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            if (apb.penable) begin
               proto_d = 1'b1;
            end else if (|apb.psel) begin
               state_d  = ACCESS;
               bank_d   = bank_sel;
               word_d   = word_sel;
               pwrite_d = apb.pwrite;
               paddr_d  = apb.paddr;
               wcnt_d   = cfg_wait_states;
               err_d    = setup_err;
               if (cfg_wait_states == '0) begin
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  if (!apb.pwrite && !setup_err) prdata_d = mem_q[bank_sel][word_sel];
               end
            end
         end
         ACCESS: begin
            // Master dropped or altered the transfer: abandon without side effects.
            if (!apb.psel[bank_q] || apb.paddr != paddr_q || apb.pwrite != pwrite_q) begin
               proto_d   = 1'b1;
               state_d   = IDLE;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
               prdata_d  = '0;
            end else if (pready_q) begin
               if (apb.penable) begin
                  state_d   = IDLE;
                  pready_d  = 1'b0;
                  pslverr_d = 1'b0;
                  prdata_d  = '0;
                  if (err_q) begin
                     if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  end else if (pwrite_q) begin
                     mem_we = 1'b1;
                     if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
                  end else begin
                     if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
                  end
               end
            end else begin
               wcnt_d = wcnt_q - WAIT_WIDTH'(1);
               if (wcnt_q == WAIT_WIDTH'(1)) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  if (!pwrite_q && !err_q) prdata_d = mem_q[bank_q][word_q];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= IDLE;
         bank_q    <= '0;
         word_q    <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
         proto_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         word_q    <= word_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
         proto_q   <= proto_d;
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
               mem_q[s][w] <= '0;
            end
         end
      end else if (mem_we) begin
         mem_q[bank_q][word_q] <= wr_merge;
      end
   end

   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign rd_count    = rd_cnt_q;
   assign wr_count    = wr_cnt_q;
   assign err_count   = err_cnt_q;
   assign proto_err   = proto_q;
endmodule

// File: tb/tb_slave_agent_mem_bfm.sv
// Directed bench for slave_agent_mem_bfm with two banks and hand-computed expectations.
module tb_slave_agent_mem_bfm;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 2;
   localparam int WW = 4;

   logic          pclk = 1'b0;
   logic          preset_n = 1'b0;
   logic [WW-1:0] cfg_wait_states;
   logic          cfg_err_inject;
   logic [15:0]   rd_count, wr_count, err_count;
   logic          proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] rd;
   logic          se;
   int            acc;

   slave_agent_mem_bfm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

   slave_agent_mem_bfm #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .NUM_SLAVES(NS), .WAIT_WIDTH(WW)
   ) dut (
      .pclk            (pclk),
      .preset_n        (preset_n),
      .apb             (bus),
      .cfg_wait_states (cfg_wait_states),
      .cfg_err_inject  (cfg_err_inject),
      .rd_count        (rd_count),
      .wr_count        (wr_count),
      .err_count       (err_count),
      .proto_err       (proto_err)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.psel        = '0;
      bus.penable     = 1'b0;
      bus.pwrite      = 1'b0;
      bus.paddr       = '0;
      bus.pwdata      = '0;
      bus.pstrb       = '0;
      cfg_wait_states = '0;
      cfg_err_inject  = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the completion edge with the bus idle.
   task automatic xfer(input logic [NS-1:0] sel, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [3:0] strb, input int waits,
                       input logic inject, output logic [DW-1:0] rdata, output logic slverr,
                       output int acc_cyc);
      bus.psel        = sel;
      bus.penable     = 1'b0;
      bus.pwrite      = wr;
      bus.paddr       = addr;
      bus.pwdata      = wdata;
      bus.pstrb       = strb;
      cfg_wait_states = WW'(waits);
      cfg_err_inject  = inject;
      @(negedge pclk);
      bus.penable = 1'b1;
      acc_cyc = 1;
      while (!bus.pready && acc_cyc < 40) begin
         @(negedge pclk);
         acc_cyc++;
      end
      if (!bus.pready) chk("pready_timeout", 64'(bus.pready), 64'd1);
      rdata  = bus.prdata;
      slverr = bus.pslverr;
      @(negedge pclk);
      bus_idle();
   endtask

   initial begin
      bus_idle();
      repeat (3) @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      chk("rst_pready",  64'(bus.pready),  64'd0);
      chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
      chk("rst_prdata",  64'(bus.prdata),  64'd0);
      chk("rst_counts",  {16'd0, rd_count, wr_count, err_count}, 64'd0);
      chk("rst_proto",   64'(proto_err),   64'd0);

      // Zero-wait write then read
      xfer(2'b01, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, se, acc);
      chk("zw_wr_acc",    64'(acc), 64'd1);
      chk("zw_wr_slverr", 64'(se),  64'd0);
      chk("zw_wr_cnt",    64'(wr_count), 64'd1);
      chk("zw_pready_low", 64'(bus.pready), 64'd0);
      xfer(2'b01, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("zw_rd_acc",  64'(acc), 64'd1);
      chk("zw_rd_data", 64'(rd),  64'hDEADBEEF);
      chk("zw_rd_cnt",  64'(rd_count), 64'd1);

      // Strobed write with three wait states
      xfer(2'b01, 1'b1, 32'h10, 32'h11223344, 4'b0101, 3, 1'b0, rd, se, acc);
      chk("st_wr_acc", 64'(acc), 64'd4);
      xfer(2'b01, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("st_rd_data", 64'(rd), 64'hDE22BE44);
      chk("st_counts",  {32'd0, rd_count, wr_count}, {32'd0, 16'd2, 16'd2});

      // Error paths
      xfer(2'b01, 1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("oor_slverr", 64'(se), 64'd1);
      chk("oor_prdata", 64'(rd), 64'd0);
      chk("oor_errcnt", 64'(err_count), 64'd1);
      chk("oor_rdcnt",  64'(rd_count),  64'd2);
      xfer(2'b01, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 2, 1'b1, rd, se, acc);
      chk("inj_slverr", 64'(se), 64'd1);
      chk("inj_errcnt", 64'(err_count), 64'd2);
      chk("inj_wrcnt",  64'(wr_count),  64'd2);
      xfer(2'b01, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("inj_mem", 64'(rd), 64'hDE22BE44);
      xfer(2'b11, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("mh_slverr", 64'(se), 64'd1);
      chk("mh_errcnt", 64'(err_count), 64'd3);

      // Banking
      xfer(2'b01, 1'b1, 32'h0, 32'hA, 4'hF, 0, 1'b0, rd, se, acc);
      xfer(2'b10, 1'b1, 32'h0, 32'hB, 4'hF, 1, 1'b0, rd, se, acc);
      xfer(2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("bank0", 64'(rd), 64'hA);
      xfer(2'b10, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("bank1", 64'(rd), 64'hB);
      chk("bank_counts", {32'd0, rd_count, wr_count}, {32'd0, 16'd5, 16'd4});
      chk("proto_clean", 64'(proto_err), 64'd0);

      // penable in IDLE
      bus.penable = 1'b1;
      @(negedge pclk);
      bus.penable = 1'b0;
      @(negedge pclk);
      chk("proto_idle_pen", 64'(proto_err), 64'd1);

      preset_n = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      chk("proto_cleared", 64'(proto_err), 64'd0);

      // psel dropped during a wait state
      xfer(2'b01, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 1'b0, rd, se, acc);
      bus.psel = 2'b01; bus.pwrite = 1'b1; bus.paddr = 32'h20;
      bus.pwdata = 32'hFFFFFFFF; bus.pstrb = 4'hF; cfg_wait_states = 4'd3;
      @(negedge pclk);
      bus.penable = 1'b1;
      @(negedge pclk);
      bus_idle();
      @(negedge pclk);
      chk("drop_proto",  64'(proto_err), 64'd1);
      chk("drop_pready", 64'(bus.pready), 64'd0);
      chk("drop_wrcnt",  64'(wr_count),  64'd1);
      xfer(2'b01, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("drop_mem", 64'(rd), 64'h12345678);

      // Reset in the middle of a five-wait write
      bus.psel = 2'b01; bus.pwrite = 1'b1; bus.paddr = 32'h30;
      bus.pwdata = 32'hCAFEF00D; bus.pstrb = 4'hF; cfg_wait_states = 4'd5;
      @(negedge pclk);
      bus.penable = 1'b1;
      repeat (2) @(negedge pclk);
      preset_n = 1'b0;
      bus_idle();
      #1;
      chk("mrst_outs",   {61'd0, bus.pready, bus.pslverr, proto_err}, 64'd0);
      chk("mrst_prdata", 64'(bus.prdata), 64'd0);
      chk("mrst_counts", {16'd0, rd_count, wr_count, err_count}, 64'd0);
      @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      xfer(2'b01, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("mrst_mem30", 64'(rd), 64'd0);
      xfer(2'b01, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("mrst_mem20", 64'(rd), 64'd0);

      // Saturation
      force dut.wr_cnt_q = 16'hFFFE;
      repeat (2) @(negedge pclk);
      release dut.wr_cnt_q;
      @(negedge pclk);
      chk("sat_preload", 64'(wr_count), 64'hFFFE);
      xfer(2'b01, 1'b1, 32'h4, 32'h1, 4'hF, 0, 1'b0, rd, se, acc);
      chk("sat_1", 64'(wr_count), 64'hFFFF);
      xfer(2'b01, 1'b1, 32'h8, 32'h2, 4'hF, 0, 1'b0, rd, se, acc);
      xfer(2'b01, 1'b1, 32'hC, 32'h3, 4'hF, 0, 1'b0, rd, se, acc);
      chk("sat_3", 64'(wr_count), 64'hFFFF);
      xfer(2'b01, 1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0, rd, se, acc);
      chk("sat_mem", 64'(rd), 64'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
